// File: rtl/maxpool_stage.sv
// Per-lane 2x2 / stride-2 max pooling over a row-major stream of nine-lane pixels.
// Optional MAXPOOL_FRAME_DONE_EN adds a frame_done pulse on the last pooled output of each frame.
module maxpool_stage #(
  parameter int int_bits = 13,
  parameter int W        = 8,
  parameter int H        = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         in_valid,
  input  logic [8:0][int_bits-1:0]     in,
  output logic                         out_valid,
  output logic [8:0][int_bits-1:0]     out,
`ifdef MAXPOOL_FRAME_DONE_EN
  output logic                         frame_done,
`endif
  output logic [11:0]                  out_idx
);

  localparam int CW    = $clog2(W);
  localparam int RW    = $clog2(H);
  localparam int PW    = W / 2;
  localparam int PH    = H / 2;
  localparam int AW    = (PW > 1) ? $clog2(PW) : 1;
  localparam int TOTAL = PW * PH;

  localparam logic [CW-1:0] COL_LAST = CW'(W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);
  localparam logic [11:0]   IDX_LAST = 12'(TOTAL - 1);

  logic [CW-1:0]               col_q, col_d;
  logic [RW-1:0]               row_q, row_d;
  logic [11:0]                 cnt_q, cnt_d;
  logic [11:0]                 out_idx_q, out_idx_d;
  logic                        out_valid_q, out_valid_d;
  logic [8:0][int_bits-1:0]    left_q, left_d;
  logic [8:0][int_bits-1:0]    out_q, out_d;
  logic [8:0][int_bits-1:0]    hmax, pooled, buf_rd;
  logic [8:0][int_bits-1:0]    line_buf_q [PW];
  logic [AW-1:0]               addr;
  logic                        wr_en;
  logic                        row_in;
`ifdef MAXPOOL_FRAME_DONE_EN
  logic                        frame_done_q, frame_done_d;
`endif

  assign addr   = AW'(col_q >> 1);
  assign buf_rd = line_buf_q[addr];
  // A trailing even row (odd H) must never land in the line buffer.
  assign row_in = (int'(row_q) < 2 * PH);

  always_comb begin
    hmax   = '0;
    pooled = '0;
    for (int l = 0; l < 9; l++) begin
      hmax[l]   = ($signed(in[l]) > $signed(left_q[l])) ? in[l] : left_q[l];
      pooled[l] = ($signed(hmax[l]) > $signed(buf_rd[l])) ? hmax[l] : buf_rd[l];
    end
  end

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    cnt_d       = cnt_q;
    out_idx_d   = out_idx_q;
    out_valid_d = 1'b0;
    left_d      = left_q;
    out_d       = out_q;
    wr_en       = 1'b0;
`ifdef MAXPOOL_FRAME_DONE_EN
    frame_done_d = 1'b0;
`endif
    if (start) begin
      col_d     = '0;
      row_d     = '0;
      cnt_d     = '0;
      out_idx_d = '0;
    end else if (in_valid) begin
      if (!col_q[0]) begin
        left_d = in;
      end else if (!row_q[0]) begin
        wr_en = row_in;
      end else begin
        // Odd columns/rows always sit inside the poolable area, so no bound check here.
        out_valid_d = 1'b1;
        out_d       = pooled;
        out_idx_d   = cnt_q;
        cnt_d       = cnt_q + 12'd1;
`ifdef MAXPOOL_FRAME_DONE_EN
        frame_done_d = (cnt_q == IDX_LAST);
`endif
      end
      if (col_q == COL_LAST) begin
        col_d = '0;
        if (row_q == ROW_LAST) begin
          row_d = '0;
          cnt_d = '0;
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q        <= '0;
      row_q        <= '0;
      cnt_q        <= '0;
      out_idx_q    <= '0;
      out_valid_q  <= 1'b0;
      left_q       <= '0;
      out_q        <= '0;
`ifdef MAXPOOL_FRAME_DONE_EN
      frame_done_q <= 1'b0;
`endif
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      cnt_q        <= cnt_d;
      out_idx_q    <= out_idx_d;
      out_valid_q  <= out_valid_d;
      left_q       <= left_d;
      out_q        <= out_d;
`ifdef MAXPOOL_FRAME_DONE_EN
      frame_done_q <= frame_done_d;
`endif
    end
  end

  // Line buffer is plain storage: every entry is rewritten on an even row before it is read.
  always_ff @(posedge clk) begin
    if (wr_en) line_buf_q[addr] <= hmax;
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign out_idx   = out_idx_q;
`ifdef MAXPOOL_FRAME_DONE_EN
  assign frame_done = frame_done_q;
`endif

endmodule

// File: tb/tb_maxpool_stage.sv
// Directed bench for maxpool_stage: a 4x4 instance for most scenarios and a 5x5 instance
// for odd-dimension trimming.
module tb_maxpool_stage;

  localparam int IB = 13;

  logic clk;
  logic reset;

  logic                  start4, iv4, ov4;
  logic [8:0][IB-1:0]    in4, out4;
  logic [11:0]           idx4;
  logic                  start5, iv5, ov5;
  logic [8:0][IB-1:0]    in5, out5;
  logic [11:0]           idx5;
`ifdef MAXPOOL_FRAME_DONE_EN
  logic                  fd4, fd5;
`endif

  int checks = 0;
  int errors = 0;

  maxpool_stage #(.int_bits(IB), .W(4), .H(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .in_valid(iv4), .in(in4),
    .out_valid(ov4), .out(out4),
`ifdef MAXPOOL_FRAME_DONE_EN
    .frame_done(fd4),
`endif
    .out_idx(idx4)
  );

  maxpool_stage #(.int_bits(IB), .W(5), .H(5)) u_dut5 (
    .clk(clk), .reset(reset), .start(start5), .in_valid(iv5), .in(in5),
    .out_valid(ov5), .out(out5),
`ifdef MAXPOOL_FRAME_DONE_EN
    .frame_done(fd5),
`endif
    .out_idx(idx5)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic drive4(input logic s, input logic v, input int l0, input int l1, input int l4);
    start4 = s;
    iv4    = v;
    in4    = '0;
    in4[0] = IB'(l0);
    in4[1] = IB'(l1);
    in4[4] = IB'(l4);
    @(posedge clk);
    #1;
  endtask

  task automatic drive5(input logic v, input int l0);
    start5 = 1'b0;
    iv5    = v;
    in5    = '0;
    in5[0] = IB'(l0);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ov4 !== 1'b0 || out4 !== '0 || idx4 !== 12'd0) begin
      errors++;
      $display("FAIL reset4 got ov=%0b out=%h idx=%0d want 0", ov4, out4, idx4);
    end
    checks++;
    if (ov5 !== 1'b0 || out5 !== '0 || idx5 !== 12'd0) begin
      errors++;
      $display("FAIL reset5 got ov=%0b out=%h idx=%0d want 0", ov5, out5, idx5);
    end
    reset = 1'b1;
  endtask

  // Lane0 = base+p, lane1 = base+15-p; block maxima hand-computed.
  task automatic test_frame4(input int base, input bit gaps);
    int m0[4] = '{5, 7, 13, 15};
    int m1[4] = '{15, 13, 7, 5};
    int npulse = 0;
    drive4(1'b1, 1'b0, 0, 0, 0);
    for (int p = 0; p < 16; p++) begin
      int r = p / 4;
      int c = p % 4;
      int k = (r / 2) * 2 + c / 2;
      logic ev = ((r % 2) == 1) && ((c % 2) == 1);
      drive4(1'b0, 1'b1, base + p, base + 15 - p, 0);
      checks++;
      if (ov4 !== ev) begin
        errors++;
        $display("FAIL frame4_valid p=%0d got %0b want %0b", p, ov4, ev);
      end
      if (ev) begin
        npulse++;
        checks++;
        if (out4[0] !== IB'(base + m0[k]) || out4[1] !== IB'(base + m1[k]) || idx4 !== 12'(k)) begin
          errors++;
          $display("FAIL frame4_data p=%0d got l0=%0d l1=%0d idx=%0d want l0=%0d l1=%0d idx=%0d",
                   p, out4[0], out4[1], idx4, base + m0[k], base + m1[k], k);
        end
      end
      if (gaps) begin
        drive4(1'b0, 1'b0, 999, 999, 999);
        checks++;
        if (ov4 !== 1'b0) begin
          errors++;
          $display("FAIL gap_valid p=%0d got %0b want 0", p, ov4);
        end
      end
    end
    checks++;
    if (npulse != 4) begin
      errors++;
      $display("FAIL frame4_pulses got %0d want 4", npulse);
    end
  endtask

  task automatic test_signed();
    drive4(1'b1, 1'b0, 0, 0, 0);
    for (int p = 0; p < 16; p++) begin
      int v4;
      case (p)
        0: v4 = -3;    1: v4 = -8;    4: v4 = -1;    5: v4 = -6;
        2: v4 = -100;  3: v4 = -20;   6: v4 = -300;  7: v4 = -50;
        default: v4 = 0;
      endcase
      drive4(1'b0, 1'b1, 0, 0, v4);
      if (p == 5) begin
        checks++;
        if (ov4 !== 1'b1 || $signed(out4[4]) !== -13'sd1) begin
          errors++;
          $display("FAIL signed_blk0 got ov=%0b l4=%0d want 1 -1", ov4, $signed(out4[4]));
        end
      end
      if (p == 7) begin
        checks++;
        if (ov4 !== 1'b1 || $signed(out4[4]) !== -13'sd20) begin
          errors++;
          $display("FAIL signed_blk1 got ov=%0b l4=%0d want 1 -20", ov4, $signed(out4[4]));
        end
      end
    end
  endtask

  // Entered at a frame boundary with out_idx holding 3 from the previous frame.
  task automatic test_start();
    for (int p = 0; p < 5; p++) drive4(1'b0, 1'b1, p, 0, 0);
    drive4(1'b1, 1'b1, 5, 0, 0);
    checks++;
    if (ov4 !== 1'b0 || idx4 !== 12'd0) begin
      errors++;
      $display("FAIL start_drop got ov=%0b idx=%0d want 0 0", ov4, idx4);
    end
    for (int p = 0; p < 6; p++) begin
      drive4(1'b0, 1'b1, 300 + p, 0, 0);
      checks++;
      if (ov4 !== (p == 5)) begin
        errors++;
        $display("FAIL start_restart_valid p=%0d got %0b want %0b", p, ov4, (p == 5));
      end
    end
    checks++;
    if (out4[0] !== IB'(305) || idx4 !== 12'd0) begin
      errors++;
      $display("FAIL start_restart_data got l0=%0d idx=%0d want 305 0", out4[0], idx4);
    end
  endtask

  task automatic test_back_to_back();
    int m0[4] = '{5, 7, 13, 15};
    drive4(1'b1, 1'b0, 0, 0, 0);
    for (int f = 0; f < 2; f++) begin
      for (int p = 0; p < 16; p++) begin
        int r = p / 4;
        int c = p % 4;
        int k = (r / 2) * 2 + c / 2;
        logic ev = ((r % 2) == 1) && ((c % 2) == 1);
        drive4(1'b0, 1'b1, 50 * f + p, 0, 0);
        checks++;
        if (ov4 !== ev || (ev && (out4[0] !== IB'(50 * f + m0[k]) || idx4 !== 12'(k)))) begin
          errors++;
          $display("FAIL b2b f=%0d p=%0d got ov=%0b l0=%0d idx=%0d want ov=%0b l0=%0d idx=%0d",
                   f, p, ov4, out4[0], idx4, ev, 50 * f + m0[k], k);
        end
`ifdef MAXPOOL_FRAME_DONE_EN
        checks++;
        if (fd4 !== (p == 15)) begin
          errors++;
          $display("FAIL frame_done f=%0d p=%0d got %0b want %0b", f, p, fd4, (p == 15));
        end
`endif
      end
    end
  endtask

  task automatic test_reset_mid();
    drive4(1'b1, 1'b0, 0, 0, 0);
    for (int p = 0; p < 6; p++) drive4(1'b0, 1'b1, p, 0, 0);
    checks++;
    if (ov4 !== 1'b1 || out4[0] !== IB'(5)) begin
      errors++;
      $display("FAIL reset_mid_pre got ov=%0b l0=%0d want 1 5", ov4, out4[0]);
    end
    iv4   = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (ov4 !== 1'b0 || out4 !== '0 || idx4 !== 12'd0) begin
      errors++;
      $display("FAIL reset_mid_async got ov=%0b out=%h idx=%0d want 0", ov4, out4, idx4);
    end
    #2;
    reset = 1'b1;
    for (int p = 0; p < 6; p++) begin
      drive4(1'b0, 1'b1, 200 + p, 0, 0);
      checks++;
      if (ov4 !== (p == 5)) begin
        errors++;
        $display("FAIL reset_mid_resume_valid p=%0d got %0b want %0b", p, ov4, (p == 5));
      end
    end
    checks++;
    if (out4[0] !== IB'(205) || idx4 !== 12'd0) begin
      errors++;
      $display("FAIL reset_mid_resume_data got l0=%0d idx=%0d want 205 0", out4[0], idx4);
    end
  endtask

  // Column 4 and row 4 carry 1000 so any leak into the result is visible.
  task automatic test_5x5();
    int m5[4] = '{6, 8, 16, 18};
    int npulse = 0;
    for (int p = 0; p < 25; p++) begin
      int r = p / 5;
      int c = p % 5;
      int k = (r / 2) * 2 + c / 2;
      int v = (r == 4 || c == 4) ? 1000 : r * 5 + c;
      logic ev = ((r % 2) == 1) && ((c % 2) == 1);
      drive5(1'b1, v);
      checks++;
      if (ov5 !== ev) begin
        errors++;
        $display("FAIL odd5_valid p=%0d got %0b want %0b", p, ov5, ev);
      end
      if (ev) begin
        npulse++;
        checks++;
        if (out5[0] !== IB'(m5[k]) || idx5 !== 12'(k)) begin
          errors++;
          $display("FAIL odd5_data p=%0d got l0=%0d idx=%0d want l0=%0d idx=%0d",
                   p, out5[0], idx5, m5[k], k);
        end
      end
`ifdef MAXPOOL_FRAME_DONE_EN
      checks++;
      if (fd5 !== (p == 18)) begin
        errors++;
        $display("FAIL odd5_frame_done p=%0d got %0b want %0b", p, fd5, (p == 18));
      end
`endif
    end
    drive5(1'b0, 0);
    checks++;
    if (npulse != 4 || ov5 !== 1'b0) begin
      errors++;
      $display("FAIL odd5_pulses got %0d ov=%0b want 4 0", npulse, ov5);
    end
  endtask

  initial begin
    reset  = 1'b0;
    start4 = 1'b0;
    iv4    = 1'b0;
    in4    = '0;
    start5 = 1'b0;
    iv5    = 1'b0;
    in5    = '0;
    test_reset();
    test_frame4(0, 1'b0);
    test_signed();
    test_start();
    test_frame4(10, 1'b1);
    test_back_to_back();
    test_reset_mid();
    test_5x5();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
